// File: rtl/decode_issue_controller.sv
// Decode-stage controller: classifies each fetched instruction, builds its
// immediate and register fields, and queues the bundle in a 2-entry skid
// buffer between fetch and execute. Defining DECODE_STATS_EN adds
// issued/illegal pop counters (stat_issued, stat_illegal).

module immediate_generator (
  input  logic [31:7] instr_hi,
  input  logic [2:0]  inst_type,
  output logic [31:0] immediate
);

  // Assemble the sign-extended immediate for the given instruction format
  always_comb begin
    immediate = '0;
    case (inst_type)
      3'b000: immediate = {{20{instr_hi[31]}}, instr_hi[31:20]};
      3'b001: immediate = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      3'b010: immediate = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                           instr_hi[30:25], instr_hi[11:8], 1'b0};
      3'b011: immediate = {instr_hi[31:12], 12'b0};
      3'b100: immediate = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                           instr_hi[20], instr_hi[30:21], 1'b0};
      default: immediate = '0;
    endcase
  end

endmodule

module decode_issue_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immediate,
  output logic [2:0]      out_inst_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_illegal
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      inst_type;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  state_t      state, next_state;
  entry_t      head, tail, incoming;
  logic [2:0]  dec_type;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic        push, pop;
  logic        load_head, load_tail, promote;

  // Classify the opcode; R-type and unknown opcodes share type 111
  always_comb begin
    dec_type    = 3'b111;
    dec_illegal = 1'b0;
    case (in_instruction[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_type = 3'b000;
      7'b0100011:                                     dec_type = 3'b001;
      7'b1100011:                                     dec_type = 3'b010;
      7'b0110111, 7'b0010111:                         dec_type = 3'b011;
      7'b1101111:                                     dec_type = 3'b100;
      7'b0110011:                                     dec_type = 3'b111;
      default:                                        dec_illegal = 1'b1;
    endcase
  end

  immediate_generator u_imm_gen (
    .instr_hi  (in_instruction[31:7]),
    .inst_type (dec_type),
    .immediate (dec_imm)
  );

  // Bundle the decoded fields into the form stored in the buffer
  always_comb begin
    incoming.imm       = dec_imm;
    incoming.inst_type = dec_type;
    incoming.rs1       = in_instruction[19:15];
    incoming.rs2       = in_instruction[24:20];
    incoming.rd        = in_instruction[11:7];
    incoming.pc        = in_pc;
    incoming.illegal   = dec_illegal;
  end

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // Next occupancy and entry-move controls; flush overrides everything
  always_comb begin
    next_state = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    promote    = 1'b0;
    in_ready   = (state != TWO);
    out_valid  = (state != EMPTY);
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          next_state = ONE;
          load_head  = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            next_state = TWO;
            load_tail  = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        TWO: if (pop) begin
          next_state = ONE;
          promote    = 1'b1;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Entry storage: head feeds execute, tail holds the overflow slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head) head <= incoming;
      else if (promote) head <= tail;
      if (load_tail) tail <= incoming;
    end
  end

  assign out_immediate = head.imm;
  assign out_inst_type = head.inst_type;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_pc        = head.pc;
  assign out_illegal   = head.illegal;

`ifdef DECODE_STATS_EN
  // Count completed issues and the illegal ones among them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else if (pop) begin
      stat_issued <= stat_issued + 32'd1;
      if (head.illegal) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_controller.sv
// Scoreboard bench for decode_issue_controller: stimulus queues the expected
// bundle when fetch offers an instruction, a negedge monitor compares every
// handshake at the execute side.

module tb_decode_issue_controller;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  inst_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_immediate;
  logic [2:0]  out_inst_type;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;
`ifdef DECODE_STATS_EN
  logic [31:0] stat_issued, stat_illegal;
  logic [31:0] base_issued, base_illegal;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  decode_issue_controller #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_immediate  (out_immediate),
    .out_inst_type  (out_inst_type),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_rd         (out_rd),
    .out_pc         (out_pc),
    .out_illegal    (out_illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_illegal   (stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offer one instruction to the controller; the expected bundle is queued
  // on the cycle fetch sees in_ready, i.e. the cycle it is accepted.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input exp_t exp_v);
    bit done = 0;
    in_valid       = 1'b1;
    in_instruction = instr;
    in_pc          = pc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_v);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for instr 0x%08h, required 1", instr);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] imm, input logic [2:0] t, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc,
                              input logic ill);
    exp_t e;
    e.imm = imm; e.inst_type = t; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.illegal = ill;
    return e;
  endfunction

  // Monitor: every execute handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t got;
      got = {out_immediate, out_inst_type, out_rs1, out_rs2, out_rd, out_pc, out_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got pc=0x%08h imm=0x%08h, required no output", out_pc, out_immediate);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("[TB] FAIL issue_pc%08h: got imm=%08h type=%0d rs1=%0d rs2=%0d rd=%0d pc=%08h ill=%0b required imm=%08h type=%0d rs1=%0d rs2=%0d rd=%0d pc=%08h ill=%0b",
                   e.pc, got.imm, got.inst_type, got.rs1, got.rs2, got.rd, got.pc, got.illegal,
                   e.imm, e.inst_type, e.rs1, e.rs2, e.rd, e.pc, e.illegal);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset_imm",       out_immediate,       32'd0);
    checkOutput("reset_type",      {29'b0, out_inst_type}, 32'd0);
    checkOutput("reset_pc",        out_pc,              32'd0);
    checkOutput("reset_illegal",   {31'b0, out_illegal}, 32'd0);

    // addi x1,x0,-1 with one-cycle latency
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093, 32'h0000_1000, mk(32'hFFFFFFFF, 3'b000, 5'd0, 5'd31, 5'd1, 32'h0000_1000, 1'b0));
    checkOutput("latency_out_valid", {31'b0, out_valid}, 32'd1);

    // Back-to-back formats
    applyStimulus(32'h0020A423, 32'h0000_1004, mk(32'h00000008, 3'b001, 5'd1, 5'd2, 5'd8,  32'h0000_1004, 1'b0));
    applyStimulus(32'hFE000EE3, 32'h0000_1008, mk(32'hFFFFFFFC, 3'b010, 5'd0, 5'd0, 5'd29, 32'h0000_1008, 1'b0));
    applyStimulus(32'h123452B7, 32'h0000_100C, mk(32'h12345000, 3'b011, 5'd8, 5'd3, 5'd5,  32'h0000_100C, 1'b0));
    applyStimulus(32'h001000EF, 32'h0000_1010, mk(32'h00000800, 3'b100, 5'd0, 5'd1, 5'd1,  32'h0000_1010, 1'b0));
    repeat (2) @(posedge clk); #1;

    // Fill with execute stalled, third instruction held by fetch
    out_ready = 1'b0;
    applyStimulus(32'h00500113, 32'h0000_2000, mk(32'h00000005, 3'b000, 5'd0, 5'd5,  5'd2, 32'h0000_2000, 1'b0));
    applyStimulus(32'h00A00193, 32'h0000_2004, mk(32'h0000000A, 3'b000, 5'd0, 5'd10, 5'd3, 32'h0000_2004, 1'b0));
    @(negedge clk);
    checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("full_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    fork
      applyStimulus(32'hFFE00213, 32'h0000_2008, mk(32'hFFFFFFFE, 3'b000, 5'd0, 5'd30, 5'd4, 32'h0000_2008, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    checkOutput("drain_empty", exp_q.size(), 32'd0);

    // Flush while full, with a new instruction offered the same cycle
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 32'h0000_3000, mk(32'h00000001, 3'b000, 5'd0, 5'd1, 5'd1, 32'h0000_3000, 1'b0));
    applyStimulus(32'h00200093, 32'h0000_3004, mk(32'h00000002, 3'b000, 5'd0, 5'd2, 5'd1, 32'h0000_3004, 1'b0));
    flush = 1'b1; in_valid = 1'b1; in_instruction = 32'h00300093; in_pc = 32'h0000_3008;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_in_ready",  {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    applyStimulus(32'h00400093, 32'h0000_300C, mk(32'h00000004, 3'b000, 5'd0, 5'd4, 5'd1, 32'h0000_300C, 1'b0));
    repeat (2) @(posedge clk); #1;

    // Illegal opcode followed by R-type
`ifdef DECODE_STATS_EN
    base_issued = stat_issued; base_illegal = stat_illegal;
`endif
    applyStimulus(32'h0000007F, 32'h0000_4000, mk(32'h0, 3'b111, 5'd0, 5'd0, 5'd0, 32'h0000_4000, 1'b1));
    applyStimulus(32'h00000033, 32'h0000_4004, mk(32'h0, 3'b111, 5'd0, 5'd0, 5'd0, 32'h0000_4004, 1'b0));
    repeat (2) @(posedge clk); #1;
`ifdef DECODE_STATS_EN
    checkOutput("stat_issued_delta",  stat_issued - base_issued,   32'd2);
    checkOutput("stat_illegal_delta", stat_illegal - base_illegal, 32'd1);
`endif

    // Asynchronous reset mid-cycle while full
    out_ready = 1'b0;
    applyStimulus(32'h00500093, 32'h0000_5000, mk(32'h00000005, 3'b000, 5'd0, 5'd5, 5'd1, 32'h0000_5000, 1'b0));
    applyStimulus(32'h00600093, 32'h0000_5004, mk(32'h00000006, 3'b000, 5'd0, 5'd6, 5'd1, 32'h0000_5004, 1'b0));
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("async_rst_imm",       out_immediate,       32'd0);
    checkOutput("async_rst_pc",        out_pc,              32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(32'h00700093, 32'h0000_6000, mk(32'h00000007, 3'b000, 5'd0, 5'd7, 5'd1, 32'h0000_6000, 1'b0));
    checkOutput("post_rst_latency", {31'b0, out_valid}, 32'd1);
    repeat (3) @(posedge clk); #1;
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
